// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
// Two-port round-robin arbiter and sequencer in front of a single-ported
// 64-bit data memory. Port 0 is the core load/store stage and port 1 is the
// DMA/debug port. One request is granted at a time. The winner's access is
// driven onto the memory port for exactly one cycle. A read-data or
// write-acknowledge response is then held until the winner consumes it.
//
// Ports:
//   clockInput          clock, rising edge
//   resetNInput         asynchronous active-low reset
//   reqValidInput[1:0]  request valid per port
//   reqReadyOutput[1:0] request accepted when valid & ready (IDLE only)
//   reqWriteInput[1:0]  1 = store, 0 = load, per port
//   reqAddr0/1Input     request address per port
//   reqWriteData0/1Input store data per port
//   respValidOutput[1:0] response valid per port
//   respReadyInput[1:0] response consumed per port
//   respReadDataOutput  captured load data, shared between ports
//   memWriteOutput      memory write enable
//   memReadOutput       memory read enable
//   memAddressOutput    memory address (full width, memory decodes low bits)
//   memWriteDataOutput  memory write data
//   memReadDataInput    combinational memory read data

module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clockInput,
  input  logic                  resetNInput,
  input  logic [1:0]            reqValidInput,
  output logic [1:0]            reqReadyOutput,
  input  logic [1:0]            reqWriteInput,
  input  logic [ADDR_WIDTH-1:0] reqAddr0Input,
  input  logic [ADDR_WIDTH-1:0] reqAddr1Input,
  input  logic [DATA_WIDTH-1:0] reqWriteData0Input,
  input  logic [DATA_WIDTH-1:0] reqWriteData1Input,
  output logic [1:0]            respValidOutput,
  input  logic [1:0]            respReadyInput,
  output logic [DATA_WIDTH-1:0] respReadDataOutput,
  output logic                  memWriteOutput,
  output logic                  memReadOutput,
  output logic [ADDR_WIDTH-1:0] memAddressOutput,
  output logic [DATA_WIDTH-1:0] memWriteDataOutput,
  input  logic [DATA_WIDTH-1:0] memReadDataInput
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_lastGrant;
  logic                  r_id;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [1:0]            w_grant;
  logic                  w_accept;
  logic                  w_winner;

  // Round-robin grant. Only offered in IDLE. Gated by reset so that
  // reqReady reads 0 while reset is held, even with requests pending.
  // When both ports ask, the one that did not win last time gets it.
  always_comb begin
    w_grant = 2'b00;
    if (resetNInput && (r_state == ST_IDLE)) begin
      case (reqValidInput)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_lastGrant ? 2'b01 : 2'b10;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_accept = |w_grant;
  assign w_winner = w_grant[1];

  // Next-state logic. ACCESS always lasts a single cycle. RESP waits only
  // on the ready of the port that owns the response.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_nextState = ST_ACCESS;
      ST_ACCESS: w_nextState = ST_RESP;
      ST_RESP:   if (respReadyInput[r_id]) w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Output decode. Memory controls are only live in ACCESS. Because the
  // decode is from state, an async reset in ACCESS removes the write enable
  // before the next edge.
  always_comb begin
    reqReadyOutput     = w_grant;
    respValidOutput    = 2'b00;
    memWriteOutput     = 1'b0;
    memReadOutput      = 1'b0;
    memAddressOutput   = '0;
    memWriteDataOutput = '0;
    case (r_state)
      ST_ACCESS: begin
        memWriteOutput     = r_write;
        memReadOutput      = ~r_write;
        memAddressOutput   = r_addr;
        memWriteDataOutput = r_wdata;
      end
      ST_RESP: begin
        respValidOutput[r_id] = 1'b1;
      end
      default: ;
    endcase
  end

  assign respReadDataOutput = r_rdata;

  // State, arbitration history, request latch and response data.
  // A store response leaves r_rdata untouched.
  always_ff @(posedge clockInput or negedge resetNInput) begin
    if (!resetNInput) begin
      r_state     <= ST_IDLE;
      r_lastGrant <= 1'b1;
      r_id        <= 1'b0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_id        <= w_winner;
        r_lastGrant <= w_winner;
        r_write     <= reqWriteInput[w_winner];
        r_addr      <= w_winner ? reqAddr1Input : reqAddr0Input;
        r_wdata     <= w_winner ? reqWriteData1Input : reqWriteData0Input;
      end
      if ((r_state == ST_ACCESS) && !r_write) begin
        r_rdata <= memReadDataInput;
      end
    end
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Two-requester arbiter and sequencer in front of the 64-bit data memory: port 0 is the core load/store stage, port 1 the DMA/debug port. Each port uses a valid/ready request and a valid/ready response. The block grants one request at a time round-robin, drives the memory's single read/write port for exactly one cycle, and returns read data or a write acknowledge to the winner. The memory reads combinationally and writes on the clock edge.

Parameters:
ADDR_WIDTH, 48, request/memory address width
DATA_WIDTH, 64, data width

Ports:
clockInput  in  1  clock, rising edge
resetNInput  in  1  asynchronous active-low reset
reqValidInput  in  2  request valid, bit i = port i
reqReadyOutput  out  2  request accepted when valid&ready
reqWriteInput  in  2  1=store, 0=load, per port
reqAddr0Input / reqAddr1Input  in  ADDR_WIDTH  request address
reqWriteData0Input / reqWriteData1Input  in  DATA_WIDTH  store data
respValidOutput  out  2  response valid per port
respReadyInput  in  2  response consumed per port
respReadDataOutput  out  DATA_WIDTH  load data, shared; meaningful only for the port whose respValid is set
memWriteOutput  out  1  to memory write enable
memReadOutput  out  1  to memory read enable
memAddressOutput  out  ADDR_WIDTH  to memory address
memWriteDataOutput  out  DATA_WIDTH  to memory write data
memReadDataInput  in  DATA_WIDTH  from memory read data (combinational)

Behaviour:
- Reset (resetNInput=0, async): state IDLE; lastGrant=1 so port 0 wins first contention; all outputs 0, including memWrite/memRead, all address/data outputs, respValid and reqReady. Latched request registers are cleared.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE: reqReadyOutput = grant vector, combinational from reqValid and lastGrant. The vector is one-hot or zero and is never 2'b11.
  - Only one port valid: that port wins.
  - Both ports valid: the port != lastGrant wins.
  - On handshake, latch port id, write flag, address and write data; update lastGrant; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS (exactly 1 cycle): drive memAddressOutput and memWriteDataOutput from the latch.
  - memWriteOutput=1 for a store; memReadOutput=1 for a load; never both.
  - Load: capture memReadDataInput into the response register on the closing edge.
  - Store: the memory commits on the closing edge; the response data register is unchanged.
  - Go to RESP.
- RESP: respValidOutput[id]=1; respReadDataOutput holds the captured data.
  - Hold until respReadyInput[id]=1, then go to IDLE. respReadyInput of the other port is ignored.
  - Memory controls are 0 in IDLE and RESP.
- Latency: handshake at edge T; memory access in cycle T+1; respValid from cycle T+2; earliest next accept is in the cycle after response consumption. Peak throughput is 1 transaction per 3 cycles.
- reqReadyOutput=0 outside IDLE. Requesters must hold valid and payload until accepted; a valid dropped before acceptance is not served.
- Address passes through full width; the memory decodes its own low bits.
- Reset during ACCESS: memWriteOutput drops to 0 immediately, so no write occurs at the next edge. Reset during RESP discards the response.
- A request arriving while RESP is being consumed is accepted only in the following IDLE cycle.

Test Plan:
- Reset then single store: port0 store addr=5, data=64'hDEAD_BEEF -> reqReady[0]=1 that cycle; next cycle memWrite=1, memAddress=5; then respValid=2'b01; ack with respReady[0].
- Load after store: port1 load addr=5, memory returns DEAD_BEEF -> memRead=1 for one cycle; respValid=2'b10, respReadData=64'hDEAD_BEEF held for 3 cycles while respReady[1]=0, released on respReady[1]=1.
- Contention right after reset: both ports valid -> port0 served first, port1 next. Keep both valid continuously -> grants alternate 0,1,0,1 over 4 transactions; reqReady never 2'b11.
- Backpressure: port0 response left unconsumed for 10 cycles with port1 valid -> reqReady stays 0; memRead/memWrite stay 0; port1 is accepted in the IDLE cycle after respReady[0].
- Reset mid-ACCESS: store addr=7 data=1, pull resetNInput low during the ACCESS cycle -> memWriteOutput=0 immediately and memory[7] unchanged; after release, first accept goes to port0 when both are valid.
- Width check: load addr=48'hFFFF_FFFF_FFC0 -> memAddressOutput equals the full 48-bit value; the response matches the memory output.
